// File: rtl/mu0_memory.sv
// rtl/mu0_memory.sv - MU0 memory system: 4080x16 RAM, LED/switch ports, cycle counter and reload timer.
// Reads are combinational. The loader port owns the RAM write path whenever load_en is high.
module mu0_memory (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] address,
   input  logic [15:0] wr_data,
   input  logic        memory_read,
   input  logic        memory_write,
   output logic [15:0] rd_data,
   input  logic        load_en,
   input  logic [11:0] load_addr,
   input  logic [15:0] load_data,
   input  logic [15:0] switches,
   output logic [15:0] leds,
   output logic        timer_flag
);

   localparam logic [11:0] RAM_TOP     = 12'hFF0;
   localparam logic [11:0] ADDR_LED    = 12'hFF0;
   localparam logic [11:0] ADDR_SWITCH = 12'hFF1;
   localparam logic [11:0] ADDR_CYCLE  = 12'hFF2;
   localparam logic [11:0] ADDR_RELOAD = 12'hFF3;
   localparam logic [11:0] ADDR_COUNT  = 12'hFF4;
   localparam logic [11:0] ADDR_STATUS = 12'hFF5;

   logic [15:0] ram_q [0:4079];

   logic [15:0] led_q,    led_d;
   logic [15:0] sw_s1_q,  sw_s1_d;
   logic [15:0] sw_s2_q,  sw_s2_d;
   logic [15:0] cycle_q,  cycle_d;
   logic [15:0] reload_q, reload_d;
   logic [15:0] count_q,  count_d;
   logic        enable_q, enable_d;
   logic        flag_q,   flag_d;

   logic        ram_we;
   logic [11:0] ram_waddr;
   logic [15:0] ram_wdata;
   logic        bus_wr;
   logic        expire;

   // The loader takes priority and silently swallows any bus write in the same cycle.
   assign bus_wr = memory_write && !load_en;

   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = address;
      ram_wdata = wr_data;
      if (load_en) begin
         if (load_addr < RAM_TOP) begin
            ram_we    = 1'b1;
            ram_waddr = load_addr;
            ram_wdata = load_data;
         end
      end else if (memory_write && (address < RAM_TOP)) begin
         ram_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram_q[ram_waddr] <= ram_wdata;
      end
   end

   always_comb begin
      led_d    = led_q;
      sw_s1_d  = switches;
      sw_s2_d  = sw_s1_q;
      cycle_d  = cycle_q + 16'd1;
      reload_d = reload_q;
      count_d  = count_q;
      enable_d = enable_q;
      flag_d   = flag_q;
      expire   = 1'b0;

      if (enable_q) begin
         if (count_q == 16'd0) begin
            expire  = 1'b1;
            count_d = reload_q;
         end else begin
            count_d = count_q - 16'd1;
         end
      end

      if (bus_wr) begin
         case (address)
            ADDR_LED:    led_d    = wr_data;
            ADDR_RELOAD: reload_d = wr_data;
            ADDR_COUNT:  count_d  = wr_data;
            ADDR_STATUS: begin
               enable_d = wr_data[1];
               if (wr_data[0]) begin
                  flag_d = 1'b0;
               end
            end
            default: ;
         endcase
      end

      // Expiry is applied last so a simultaneous W1C loses.
      if (expire) begin
         flag_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led_q    <= 16'h0000;
         sw_s1_q  <= 16'h0000;
         sw_s2_q  <= 16'h0000;
         cycle_q  <= 16'h0000;
         reload_q <= 16'h0000;
         count_q  <= 16'h0000;
         enable_q <= 1'b0;
         flag_q   <= 1'b0;
      end else begin
         led_q    <= led_d;
         sw_s1_q  <= sw_s1_d;
         sw_s2_q  <= sw_s2_d;
         cycle_q  <= cycle_d;
         reload_q <= reload_d;
         count_q  <= count_d;
         enable_q <= enable_d;
         flag_q   <= flag_d;
      end
   end

   always_comb begin
      rd_data = 16'h0000;
      if (memory_read) begin
         if (address < RAM_TOP) begin
            rd_data = ram_q[address];
         end else begin
            case (address)
               ADDR_LED:    rd_data = led_q;
               ADDR_SWITCH: rd_data = sw_s2_q;
               ADDR_CYCLE:  rd_data = cycle_q;
               ADDR_RELOAD: rd_data = reload_q;
               ADDR_COUNT:  rd_data = count_q;
               ADDR_STATUS: rd_data = {14'd0, enable_q, flag_q};
               default:     rd_data = 16'h0000;
            endcase
         end
      end
   end

   assign leds       = led_q;
   assign timer_flag = flag_q;

endmodule

// File: tb/tb_mu0_memory.sv
// tb/tb_mu0_memory.sv - scoreboard bench for mu0_memory with directed vectors.
module tb_mu0_memory;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] address = '0;
   logic [15:0] wr_data = '0;
   logic        memory_read = 1'b0;
   logic        memory_write = 1'b0;
   logic [15:0] rd_data;
   logic        load_en = 1'b0;
   logic [11:0] load_addr = '0;
   logic [15:0] load_data = '0;
   logic [15:0] switches = '0;
   logic [15:0] leds;
   logic        timer_flag;

   localparam int SRC_RD   = 0;
   localparam int SRC_LED  = 1;
   localparam int SRC_FLAG = 2;

   typedef struct {
      int          src;
      logic [15:0] val;
      string       name;
   } exp_t;

   exp_t        sb[$];
   exp_t        ent;
   int          chk_n = 0;
   int          n_vec = 0;
   int          n_miss = 0;
   logic        done = 1'b0;
   logic        drained = 1'b0;
   logic [15:0] act;
   logic [15:0] tb_cyc = '0;

   mu0_memory dut (
      .clk          (clk),
      .rst          (rst),
      .address      (address),
      .wr_data      (wr_data),
      .memory_read  (memory_read),
      .memory_write (memory_write),
      .rd_data      (rd_data),
      .load_en      (load_en),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .switches     (switches),
      .leds         (leds),
      .timer_flag   (timer_flag)
   );

   always #5 clk = ~clk;

   // Independent edge counter for CYCLE reads in the middle of the run.
   always @(posedge clk) tb_cyc <= rst ? 16'h0000 : tb_cyc + 16'd1;

   always @(negedge clk) begin
      for (int i = 0; i < chk_n; i++) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_miss++;
            $display("FAIL scoreboard_underflow: no expected entry queued");
         end else begin
            ent = sb.pop_front();
            act = (ent.src == SRC_RD) ? rd_data :
                  (ent.src == SRC_LED) ? leds : {15'd0, timer_flag};
            if (act !== ent.val) begin
               n_miss++;
               $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", ent.name, act, ent.val, $time);
            end
         end
      end
      if (done && !drained) begin
         drained = 1'b1;
         n_vec++;
         if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_leftover: %0d entries remaining, expected 0", sb.size());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      memory_read  = 1'b0;
      memory_write = 1'b0;
      load_en      = 1'b0;
      chk_n        = 0;
   endtask

   task automatic expect_v(input int src, input logic [15:0] val, input string name);
      exp_t e;
      e.src  = src;
      e.val  = val;
      e.name = name;
      sb.push_back(e);
      chk_n++;
   endtask

   task automatic rd(input logic [11:0] a);
      memory_read = 1'b1;
      address     = a;
   endtask

   task automatic wr(input logic [11:0] a, input logic [15:0] d);
      memory_write = 1'b1;
      address      = a;
      wr_data      = d;
   endtask

   task automatic load(input logic [11:0] a, input logic [15:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
   endtask

   initial begin
      // Loader under reset, including an ignored bus write and out-of-range load.
      step(); rst = 1'b1; load(12'h000, 16'h0123);
      step(); load(12'h001, 16'h7000);
      step(); load(12'h002, 16'h1234);
      step(); load(12'h003, 16'h0000); wr(12'h002, 16'hDEAD);
      step(); load(12'hFF0, 16'h5555);
      step(); rd(12'hFF2);
      expect_v(SRC_LED, 16'h0000, "reset_leds");
      expect_v(SRC_FLAG, 16'h0000, "reset_flag");
      expect_v(SRC_RD, 16'h0000, "reset_cycle");
      step(); rd(12'hFF5); expect_v(SRC_RD, 16'h0000, "reset_status");
      step(); rst = 1'b0; rd(12'hFF4); expect_v(SRC_RD, 16'h0000, "reset_count");

      step(); rd(12'h000); expect_v(SRC_RD, 16'h0123, "load_ram0");
      step(); rd(12'h001); expect_v(SRC_RD, 16'h7000, "load_ram1");
      step(); rd(12'h002); expect_v(SRC_RD, 16'h1234, "load_blocks_bus_wr");
      step(); address = 12'h000; expect_v(SRC_RD, 16'h0000, "no_read_zero");

      step(); wr(12'hFF0, 16'hA5A5);
      step(); rd(12'hFF0);
      expect_v(SRC_LED, 16'hA5A5, "led_output");
      expect_v(SRC_RD, 16'hA5A5, "led_readback");
      step(); wr(12'hFF6, 16'h1234);
      step(); rd(12'hFF6); expect_v(SRC_RD, 16'h0000, "reserved_read");
      step(); wr(12'hFEF, 16'hFFFF);
      step(); wr(12'hFF2, 16'hFFFF);
      step(); rd(12'hFEF); expect_v(SRC_RD, 16'hFFFF, "ram_top_word");
      step(); rd(12'hFF2); expect_v(SRC_RD, tb_cyc, "cycle_ignores_write");

      step(); wr(12'h010, 16'h1111);
      step(); rd(12'h010); wr(12'h010, 16'h2222); expect_v(SRC_RD, 16'h1111, "rw_old_value");
      step(); rd(12'h010); expect_v(SRC_RD, 16'h2222, "rw_new_value");

      step(); switches = 16'h00FF; rd(12'hFF1); expect_v(SRC_RD, 16'h0000, "sw_lat0");
      step(); rd(12'hFF1); expect_v(SRC_RD, 16'h0000, "sw_lat1");
      step(); rd(12'hFF1); expect_v(SRC_RD, 16'h00FF, "sw_lat2");

      // Timer: RELOAD=3, COUNT=2, enable; expiries land on edges 3, 7, 11 after enable.
      step(); wr(12'hFF3, 16'h0003);
      step(); wr(12'hFF4, 16'h0002);
      step(); wr(12'hFF5, 16'h0002);
      step(); rd(12'hFF4); expect_v(SRC_RD, 16'h0002, "tmr_c1_count"); expect_v(SRC_FLAG, 16'h0000, "tmr_c1_flag");
      step(); rd(12'hFF5); expect_v(SRC_RD, 16'h0002, "tmr_status_en");
      step(); rd(12'hFF4); expect_v(SRC_RD, 16'h0000, "tmr_c3_count"); expect_v(SRC_FLAG, 16'h0000, "tmr_c3_flag");
      step(); rd(12'hFF4); expect_v(SRC_RD, 16'h0003, "tmr_reload"); expect_v(SRC_FLAG, 16'h0001, "tmr_first_expiry");
      step(); wr(12'hFF5, 16'h0003);
      step(); rd(12'hFF4); expect_v(SRC_RD, 16'h0001, "tmr_c6_count"); expect_v(SRC_FLAG, 16'h0000, "tmr_w1c");
      step(); expect_v(SRC_FLAG, 16'h0000, "tmr_c7_flag");
      step(); rd(12'hFF4); expect_v(SRC_RD, 16'h0003, "tmr_c8_count"); expect_v(SRC_FLAG, 16'h0001, "tmr_second_expiry");
      step();
      step();
      step(); rd(12'hFF5); wr(12'hFF5, 16'h0003); expect_v(SRC_RD, 16'h0003, "tmr_status_prewrite");
      step(); rd(12'hFF4); expect_v(SRC_RD, 16'h0003, "tmr_c12_count"); expect_v(SRC_FLAG, 16'h0001, "tmr_set_wins");
      step(); wr(12'hFF4, 16'h0010);
      step(); rd(12'hFF4); expect_v(SRC_RD, 16'h0010, "count_write_override");
      step(); rd(12'hFF4); expect_v(SRC_RD, 16'h000F, "count_after_override");

      // RELOAD written on an expiry edge: the old value (0) is used once, then the new one.
      step(); wr(12'hFF3, 16'h0000);
      step(); wr(12'hFF4, 16'h0000);
      step(); wr(12'hFF3, 16'h0005);
      step(); rd(12'hFF4); expect_v(SRC_RD, 16'h0000, "reload_old_used");
      step(); rd(12'hFF4); expect_v(SRC_RD, 16'h0005, "reload_new_used");
      step(); wr(12'hFF3, 16'h0000); wr(12'hFF3, 16'h0000);
      step(); wr(12'hFF4, 16'h0000);
      step(); wr(12'hFF5, 16'h0003);
      step(); expect_v(SRC_FLAG, 16'h0001, "reload0_flag_stuck");

      step(); rst = 1'b1;
      step(); rst = 1'b0; rd(12'hFF4);
      expect_v(SRC_RD, 16'h0000, "midrun_rst_count");
      expect_v(SRC_FLAG, 16'h0000, "midrun_rst_flag");
      expect_v(SRC_LED, 16'h0000, "midrun_rst_leds");
      step(); rd(12'hFF5); expect_v(SRC_RD, 16'h0000, "midrun_rst_status");
      step(); rd(12'h000); expect_v(SRC_RD, 16'h0123, "ram_survives_rst");
      step(); step(); expect_v(SRC_FLAG, 16'h0000, "flag_stays_clear");

      step(); rst = 1'b1;
      step(); rst = 1'b0; rd(12'hFF2); expect_v(SRC_RD, 16'h0000, "cycle_after_rst");
      repeat (65535) step();
      rd(12'hFF2); expect_v(SRC_RD, 16'hFFFF, "cycle_ffff");
      step(); rd(12'hFF2); expect_v(SRC_RD, 16'h0000, "cycle_wrap");

      step();
      done = 1'b1;
      step();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
